// File: rtl/pe_result_collector.sv
// ---------------------------------------------------------------------------
// pe_result_collector
//
// Collects the word stream of one processing element after the sorting mesh
// has settled.  A one-cycle start pulse opens a capture window of
// CAPTURE_CYCLES samples of i_PE.  Padding words (MAX_INT) are discarded.
// Every other word is pushed into a small FIFO.  The FIFO drains to a
// valid/ready consumer both during the capture window and afterwards.  When
// the FIFO has emptied after the window, a single o_done pulse ends the run.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous reset, active low
//   i_start    : one-cycle pulse, begin a capture run (ignored unless idle)
//   i_PE       : {addr,data} word from the upstream PE
//   o_valid    : o_data holds the FIFO head
//   i_ready    : consumer takes o_data on this edge when o_valid is high
//   o_data     : FIFO head, MAX_INT while the FIFO is empty
//   o_count    : words accepted into the FIFO this run (saturating)
//   o_busy     : run in progress (capture or drain phase)
//   o_overflow : sticky, a real word was lost because the FIFO was full
//   o_done     : one-cycle pulse at the end of a run
//
// DEPTH must be a power of two (>= 2), so pointers wrap naturally.
// CNT_WIDTH must be wide enough to represent DEPTH.
// ---------------------------------------------------------------------------
module pe_result_collector #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 3,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT =
        {(ADDR_WIDTH+DATA_WIDTH){1'b1}},
    parameter int DEPTH          = 8,
    parameter int CAPTURE_CYCLES = 8,
    parameter int CNT_WIDTH      = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_data,
    output logic [CNT_WIDTH-1:0]             o_count,
    output logic                             o_busy,
    output logic                             o_overflow,
    output logic                             o_done
);

    localparam int W     = ADDR_WIDTH + DATA_WIDTH;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int CAP_W = $clog2(CAPTURE_CYCLES + 1);

    localparam logic [CAP_W-1:0]     CAP_LAST  = CAP_W'(CAPTURE_CYCLES - 1);
    localparam logic [OCC_W-1:0]     OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] COUNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                state_q;
    logic [CAP_W-1:0]      cap_cnt_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  overflow_q;
    logic                  busy_q;
    logic                  done_q;

    logic [W-1:0]          mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [OCC_W-1:0]      occ_q;
    logic [OCC_W-1:0]      occ_d;
    logic                  valid_q;

    // -----------------------------------------------------------------------
    // Push / pop decisions
    // -----------------------------------------------------------------------
    logic sample;
    logic is_pad;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        sample    = (state_q == S_CAPTURE);
        is_pad    = (i_PE == MAX_INT);
        fifo_full = (occ_q == OCC_FULL);
        pop       = valid_q & i_ready;
        // A full FIFO can still take a word when the head leaves on the
        // same edge; the freed slot is reused immediately.
        push      = sample & ~is_pad & (~fifo_full | pop);
        drop      = sample & ~is_pad & ~push;
    end

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO storage: no reset on the array so it maps onto plain RAM.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_PE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q   <= occ_d;
            valid_q <= (occ_d != '0);
        end
    end

    // -----------------------------------------------------------------------
    // Run control FSM with registered status outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cap_cnt_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q    <= S_CAPTURE;
                        busy_q     <= 1'b1;
                        cap_cnt_q  <= '0;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                    end
                end

                S_CAPTURE: begin
                    // i_start is deliberately not looked at here: a repeat
                    // pulse must neither restart nor stretch the window.
                    cap_cnt_q <= cap_cnt_q + CAP_W'(1);
                    if (push && (count_q != COUNT_MAX)) begin
                        count_q <= count_q + CNT_WIDTH'(1);
                    end
                    if (drop) begin
                        overflow_q <= 1'b1;
                    end
                    if (cap_cnt_q == CAP_LAST) begin
                        state_q <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // Uses the current occupancy, so a final pop on this edge
                    // costs one extra drain cycle before the done pulse.
                    if (occ_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_valid    = valid_q;
    assign o_data     = valid_q ? mem[rd_ptr_q] : MAX_INT;
    assign o_count    = count_q;
    assign o_busy     = busy_q;
    assign o_overflow = overflow_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_pe_result_collector.sv
module tb_pe_result_collector;

    localparam int AW    = 3;
    localparam int DW    = 3;
    localparam int W     = AW + DW;
    localparam int DEPTH = 8;
    localparam int CC1   = 8;
    localparam int CC2   = 10;
    localparam int CNTW  = 4;
    localparam logic [W-1:0] PAD = 6'b111111;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start1 = 1'b0;
    logic          start2 = 1'b0;
    logic          ready = 1'b0;
    logic [W-1:0]  pe = 6'b111111;

    logic          v1, b1, ov1, dn1;
    logic [W-1:0]  d1;
    logic [CNTW-1:0] c1;
    logic          v2, b2, ov2, dn2;
    logic [W-1:0]  d2;
    logic [CNTW-1:0] c2;

    always #5 clk = ~clk;

    pe_result_collector #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_INT(PAD),
        .DEPTH(DEPTH), .CAPTURE_CYCLES(CC1), .CNT_WIDTH(CNTW)
    ) dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .i_PE(pe),
        .o_valid(v1), .i_ready(ready), .o_data(d1), .o_count(c1),
        .o_busy(b1), .o_overflow(ov1), .o_done(dn1)
    );

    pe_result_collector #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_INT(PAD),
        .DEPTH(DEPTH), .CAPTURE_CYCLES(CC2), .CNT_WIDTH(CNTW)
    ) dut2 (
        .clk(clk), .rst(rst), .i_start(start2), .i_PE(pe),
        .o_valid(v2), .i_ready(ready), .o_data(d2), .o_count(c2),
        .o_busy(b2), .o_overflow(ov2), .o_done(dn2)
    );

    // Which instance is under observation (0 -> dut1, 1 -> dut2)
    int sel = 0;
    logic          obs_valid, obs_busy, obs_ovf, obs_done;
    logic [W-1:0]  obs_data;
    logic [CNTW-1:0] obs_count;
    assign obs_valid = (sel == 1) ? v2  : v1;
    assign obs_busy  = (sel == 1) ? b2  : b1;
    assign obs_ovf   = (sel == 1) ? ov2 : ov1;
    assign obs_done  = (sel == 1) ? dn2 : dn1;
    assign obs_data  = (sel == 1) ? d2  : d1;
    assign obs_count = (sel == 1) ? c2  : c1;

    // Reference model / scoreboard
    logic [W-1:0] exp_q[$];
    int m_occ = 0;
    int m_st = 0;        // 0 idle, 1 capture, 2 drain, 3 done
    int m_left = 0;
    int m_count = 0;
    int m_ovf = 0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_pulses = 0;
    int pops = 0;

    task automatic model_clear();
        exp_q.delete();
        m_occ = 0; m_st = 0; m_left = 0; m_count = 0; m_ovf = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        start1 = 1'b0; start2 = 1'b0; ready = 1'b0; pe = PAD;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs at the falling edge, check the DUT state
    // left by the previous rising edge, then advance the model across the
    // coming rising edge.
    task automatic step(input logic st, input logic [W-1:0] word, input logic rdy);
        logic [W-1:0] exp_data;
        logic pop_m, samp, push_m;
        int occ_pre, cc;
        @(negedge clk);
        start1 = st && (sel == 0);
        start2 = st && (sel == 1);
        pe     = word;
        ready  = rdy;
        cyc++;

        exp_data = (m_occ != 0) ? exp_q[0] : PAD;
        vectors++;
        if (obs_valid !== (m_occ != 0)) begin
            miscompares++;
            $display("FAIL valid cyc=%0d got=%b want=%b", cyc, obs_valid, (m_occ != 0));
        end
        vectors++;
        if (obs_data !== exp_data) begin
            miscompares++;
            $display("FAIL data cyc=%0d got=%b want=%b", cyc, obs_data, exp_data);
        end
        vectors++;
        if (obs_count !== CNTW'(m_count)) begin
            miscompares++;
            $display("FAIL count cyc=%0d got=%0d want=%0d", cyc, obs_count, m_count);
        end
        vectors++;
        if (obs_ovf !== (m_ovf != 0)) begin
            miscompares++;
            $display("FAIL overflow cyc=%0d got=%b want=%b", cyc, obs_ovf, (m_ovf != 0));
        end
        vectors++;
        if (obs_busy !== (m_st == 1 || m_st == 2)) begin
            miscompares++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, obs_busy, (m_st == 1 || m_st == 2));
        end
        vectors++;
        if (obs_done !== (m_st == 3)) begin
            miscompares++;
            $display("FAIL done cyc=%0d got=%b want=%b", cyc, obs_done, (m_st == 3));
        end
        if (obs_done === 1'b1) begin
            done_pulses++;
            done_cyc = cyc;
        end

        cc      = (sel == 1) ? CC2 : CC1;
        occ_pre = m_occ;
        pop_m   = (m_occ != 0) && rdy;
        samp    = (m_st == 1);
        push_m  = samp && (word != PAD) && ((m_occ < DEPTH) || pop_m);
        if (pop_m) begin
            $display("cyc=%0d dut%0d pop %b", cyc, sel + 1, exp_q[0]);
            void'(exp_q.pop_front());
            pops++;
        end
        if (push_m) begin
            exp_q.push_back(word);
            if (m_count < 15) m_count++;
        end
        if (samp && (word != PAD) && !push_m) m_ovf = 1;
        m_occ = m_occ + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
        case (m_st)
            0: if (st) begin
                   m_st = 1; m_left = cc; m_count = 0; m_ovf = 0; start_cyc = cyc;
               end
            1: begin
                   m_left--;
                   if (m_left == 0) m_st = 2;
               end
            2: if (occ_pre == 0) m_st = 3;
            default: m_st = 0;
        endcase
    endtask

    task automatic drain(input logic rdy, input int maxc);
        int n;
        n = 0;
        while (m_st != 0 && n < maxc) begin
            step(1'b0, PAD, rdy);
            n++;
        end
        vectors++;
        if (m_st != 0) begin
            miscompares++;
            $display("FAIL drain_timeout got_state=%0d want=0", m_st);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (v1 !== 1'b0 || d1 !== PAD || c1 !== 4'd0 || b1 !== 1'b0 || ov1 !== 1'b0 || dn1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dut1 got v=%b d=%b c=%0d b=%b ov=%b dn=%b want 0 111111 0 0 0 0",
                     v1, d1, c1, b1, ov1, dn1);
        end
        vectors++;
        if (v2 !== 1'b0 || d2 !== PAD || c2 !== 4'd0 || b2 !== 1'b0 || ov2 !== 1'b0 || dn2 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dut2 got v=%b d=%b c=%0d b=%b ov=%b dn=%b want 0 111111 0 0 0 0",
                     v2, d2, c2, b2, ov2, dn2);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] pat [4];
        int dp;
        pat[0] = 6'b000101; pat[1] = PAD; pat[2] = 6'b001010; pat[3] = PAD;
        sel = 0;
        dp = done_pulses;
        step(1'b1, PAD, 1'b1);
        for (int i = 0; i < CC1; i++) step(1'b0, pat[i % 4], 1'b1);
        drain(1'b1, 40);
        vectors++;
        if (c1 !== 4'd4) begin
            miscompares++;
            $display("FAIL basic_count got=%0d want=4", c1);
        end
        vectors++;
        if (ov1 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_overflow got=%b want=0", ov1);
        end
        vectors++;
        if (done_pulses - dp != 1 || done_cyc - start_cyc != CC1 + 2) begin
            miscompares++;
            $display("FAIL basic_done got pulses=%0d delay=%0d want 1 %0d",
                     done_pulses - dp, done_cyc - start_cyc, CC1 + 2);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        sel = 0;
        step(1'b1, PAD, 1'b0);
        for (int i = 1; i <= CC1; i++) step(1'b0, W'(i), 1'b0);
        step(1'b0, PAD, 1'b0);
        step(1'b0, PAD, 1'b0);
        vectors++;
        if (v1 !== 1'b1 || d1 !== 6'b000001 || c1 !== 4'd8 || ov1 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold got v=%b d=%b c=%0d ov=%b want 1 000001 8 0", v1, d1, c1, ov1);
        end
        p0 = pops;
        drain(1'b1, 40);
        vectors++;
        if (pops - p0 != 8) begin
            miscompares++;
            $display("FAIL bp_drained got=%0d want=8", pops - p0);
        end
    endtask

    task automatic test_all_pad();
        int vseen, dp;
        sel = 0;
        vseen = 0;
        dp = done_pulses;
        step(1'b1, PAD, 1'b1);
        for (int i = 0; i < CC1; i++) begin
            step(1'b0, PAD, 1'b1);
            if (v1 === 1'b1) vseen++;
        end
        drain(1'b1, 20);
        vectors++;
        if (vseen != 0 || c1 !== 4'd0) begin
            miscompares++;
            $display("FAIL pad_valid got valid_cycles=%0d count=%0d want 0 0", vseen, c1);
        end
        vectors++;
        if (done_pulses - dp != 1 || done_cyc - start_cyc != CC1 + 2) begin
            miscompares++;
            $display("FAIL pad_done got pulses=%0d delay=%0d want 1 %0d",
                     done_pulses - dp, done_cyc - start_cyc, CC1 + 2);
        end
        step(1'b0, PAD, 1'b1);
        vectors++;
        if (b1 !== 1'b0) begin
            miscompares++;
            $display("FAIL pad_busy_after got=%b want=0", b1);
        end
    endtask

    task automatic test_overflow();
        int p0;
        do_reset();
        sel = 1;
        step(1'b1, PAD, 1'b0);
        for (int i = 1; i <= CC2; i++) step(1'b0, W'(i), 1'b0);
        step(1'b0, PAD, 1'b0);
        vectors++;
        if (c2 !== 4'd8 || ov2 !== 1'b1 || d2 !== 6'b000001) begin
            miscompares++;
            $display("FAIL ovf_state got c=%0d ov=%b d=%b want 8 1 000001", c2, ov2, d2);
        end
        p0 = pops;
        drain(1'b1, 40);
        vectors++;
        if (pops - p0 != 8) begin
            miscompares++;
            $display("FAIL ovf_drained got=%0d want=8", pops - p0);
        end
    endtask

    task automatic test_restart();
        int dp;
        sel = 1;
        dp = done_pulses;
        step(1'b1, PAD, 1'b1);
        step(1'b0, 6'b010011, 1'b1);
        vectors++;
        if (c2 !== 4'd0 || ov2 !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_clear got c=%0d ov=%b want 0 0", c2, ov2);
        end
        step(1'b0, 6'b100001, 1'b1);
        step(1'b1, 6'b011110, 1'b1);   // repeat start mid-capture
        for (int i = 4; i <= CC2; i++) step(1'b0, PAD, 1'b1);
        drain(1'b1, 20);
        vectors++;
        if (done_pulses - dp != 1 || done_cyc - start_cyc != CC2 + 2 || c2 !== 4'd3) begin
            miscompares++;
            $display("FAIL restart_len got pulses=%0d delay=%0d count=%0d want 1 %0d 3",
                     done_pulses - dp, done_cyc - start_cyc, c2, CC2 + 2);
        end
    endtask

    task automatic test_reset_mid_drain();
        int dp;
        do_reset();
        sel = 0;
        step(1'b1, PAD, 1'b0);
        step(1'b0, 6'b000011, 1'b0);
        step(1'b0, PAD, 1'b0);
        step(1'b0, 6'b010010, 1'b0);
        step(1'b0, 6'b100100, 1'b0);
        for (int i = 5; i <= CC1; i++) step(1'b0, PAD, 1'b0);
        step(1'b0, PAD, 1'b0);        // drain, three words held
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (v1 !== 1'b0 || d1 !== PAD || c1 !== 4'd0 || b1 !== 1'b0 || ov1 !== 1'b0 || dn1 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst got v=%b d=%b c=%0d b=%b ov=%b dn=%b want 0 111111 0 0 0 0",
                     v1, d1, c1, b1, ov1, dn1);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        dp = done_pulses;
        for (int i = 0; i < 4; i++) step(1'b0, PAD, 1'b1);
        vectors++;
        if (done_pulses != dp) begin
            miscompares++;
            $display("FAIL midrst_done got=%0d want=0", done_pulses - dp);
        end
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_all_pad();
        test_overflow();
        test_restart();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_result_collector.md
Name: pe_result_collector

Overview:
- Downstream consumer of a single PE's o_PE word stream. After the mesh finishes sorting, it captures that PE's {addr,data} output for a fixed window and drops MAX_INT padding words.
- Accepted words are buffered in a FIFO and drained to the readout path over a valid/ready handshake.
- It also reports the capture count, a sticky overflow flag and a completion pulse.

Parameters:
- ADDR_WIDTH, 3, address field width of a PE word (upper bits).
- DATA_WIDTH, 3, data field width of a PE word (lower bits).
- MAX_INT, 6'b111_111, padding/empty word value; width ADDR_WIDTH+DATA_WIDTH.
- DEPTH, 8, FIFO entries; power of two, >=2.
- CAPTURE_CYCLES, 8, number of cycles i_PE is sampled per run; >=1.
- CNT_WIDTH, 4, width of o_count; must hold DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse: sort complete, begin capture.
- i_PE  in  ADDR_WIDTH+DATA_WIDTH  word from the upstream PE's o_PE.
- o_valid  out  1  o_data holds the FIFO head.
- i_ready  in  1  consumer accepts o_data this cycle.
- o_data  out  ADDR_WIDTH+DATA_WIDTH  FIFO head; MAX_INT when o_valid=0.
- o_count  out  CNT_WIDTH  words accepted into the FIFO this run.
- o_busy  out  1  high in CAPTURE or DRAIN.
- o_overflow  out  1  sticky: a non-pad word was dropped because the FIFO was full.
- o_done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE, FIFO empty.
  - o_valid=0, o_data=MAX_INT, o_count=0, o_busy=0, o_overflow=0, o_done=0, capture counter=0.
  - Reset mid-run aborts the run immediately; no o_done is generated.
- State IDLE:
  - i_start=1 -> CAPTURE.
  - On that edge: capture counter=0, o_count=0, o_overflow cleared. FIFO contents are not cleared; they are empty by construction at end of DRAIN.
- State CAPTURE, lasting exactly CAPTURE_CYCLES cycles:
  - Sample i_PE on every rising edge; the counter increments per cycle.
  - Sampled word == MAX_INT -> discarded, not counted.
  - Sampled word != MAX_INT:
    - Pushed if FIFO not full, or if FIFO full and a pop occurs the same cycle.
    - Otherwise dropped and o_overflow set.
  - o_count increments per accepted push and saturates at 2^CNT_WIDTH-1.
  - After the CAPTURE_CYCLES-th sample -> DRAIN.
- State DRAIN:
  - No further sampling.
  - When the FIFO is empty -> DONE. If the FIFO is already empty on entry, DONE follows on the next cycle.
- State DONE: lasts one cycle, o_done=1, then -> IDLE.
- FIFO and handshake (draining is allowed in both CAPTURE and DRAIN):
  - o_valid = FIFO not empty, registered; a word pushed at edge k is visible at o_data after edge k (1-cycle latency).
  - Pop occurs when o_valid & i_ready at a rising edge; o_data advances to the next entry or to MAX_INT.
  - o_data and o_valid must be stable while o_valid=1 and i_ready=0.
  - Read/write pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves occupancy unchanged.
- o_busy = state in {CAPTURE, DRAIN}.
- i_start while not IDLE is ignored; it causes no restart and does not alter the counter.
- i_PE is treated as stable per cycle; no sampling in IDLE, DRAIN or DONE.

Test Plan:
- Reset, then i_start with i_PE sequence 000101,111111,001010,111111 repeating for 8 cycles and i_ready=1 -> o_count=4; o_data shows 000101,001010,000101,001010 in order, each 1 cycle after capture; o_overflow=0; a single o_done pulse after the last pop.
- i_ready=0 throughout CAPTURE with 8 non-pad words 000001..001000 and DEPTH=8 -> o_count=8, o_overflow=0, o_valid=1 with o_data=000001 held; then i_ready=1 -> 8 words drained in order, then o_done.
- i_ready=0 with CAPTURE_CYCLES=10 and 10 non-pad words -> o_count=8, o_overflow=1, words 9 and 10 absent from the drain.
- All-MAX_INT input for 8 cycles -> o_count=0, o_valid never asserted, o_done one cycle after CAPTURE ends, o_busy low after.
- Second i_start pulsed mid-CAPTURE -> ignored; run length stays 8 cycles; a subsequent run clears o_overflow and o_count.
- rst=0 asserted during DRAIN with 3 words queued -> all outputs immediately at reset values, no o_done; a new i_start then behaves as the first scenario.
